// File: rtl/memory_target_pkg.sv
// Shared constants for the memory_target responder: I/O window layout and
// STATUS register bit positions.
package memory_target_pkg;

    localparam int WIN_SIZE = 16;

    localparam logic [3:0] OFF_RXDATA = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h1;
    localparam logic [3:0] OFF_STATUS = 4'h2;
    localparam logic [3:0] OFF_CYCLES = 4'h4;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_OVF      = 2;
    localparam int ST_RX_OVF      = 3;

    function automatic logic [7:0] status_byte(input logic rx_nonempty,
                                               input logic tx_full,
                                               input logic tx_ovf,
                                               input logic rx_ovf);
        logic [7:0] s;
        s = 8'h00;
        s[ST_RX_NONEMPTY] = rx_nonempty;
        s[ST_TX_FULL]     = tx_full;
        s[ST_TX_OVF]      = tx_ovf;
        s[ST_RX_OVF]      = rx_ovf;
        return s;
    endfunction

endpackage

// File: rtl/memory_target_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop frees the head slot on the same edge.
module byte_fifo #(
    parameter int depth = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(depth);

    logic [7:0]  mem_q [depth];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/memory_target.sv
// Byte-wide memory responder: RAM below the I/O window, plus RX/TX FIFOs, a
// sticky-flag STATUS register and a coherent cycle-counter snapshot.
module memory_target
    import memory_target_pkg::*;
#(
    parameter int addr_width = 9,
    parameter int fifo_depth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] mem_raddr,
    output logic [7:0]            mem_data_out,
    input  logic [addr_width-1:0] mem_waddr,
    input  logic [7:0]            mem_data_in,
    input  logic                  mem_write,
    output logic                  mem_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid
);
    localparam int RAM_SIZE = 2**addr_width - WIN_SIZE;

    logic [7:0]            ram_q [RAM_SIZE];
    logic [addr_width-1:0] prev_raddr_q;
    logic                  first_q;
    logic                  ready_q;
    logic [7:0]            data_q, data_d;
    logic [31:0]           cnt_q;
    logic [31:0]           snap_q, snap_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  rx_ovf_q, rx_ovf_d;

    logic                  rd_win, wr_win;
    logic [3:0]            rd_off, wr_off;
    logic                  acc_start;
    logic                  ram_we;
    logic                  rx_pop, rx_empty, rx_full;
    logic [7:0]            rx_head;
    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]            tx_head;
    logic [7:0]            status;
    logic [7:0]            st_clr;

    // The window occupies the top 16 addresses, i.e. all upper bits set.
    assign rd_win = &mem_raddr[addr_width-1:4];
    assign wr_win = &mem_waddr[addr_width-1:4];
    assign rd_off = mem_raddr[3:0];
    assign wr_off = mem_waddr[3:0];

    assign acc_start = first_q | (mem_raddr != prev_raddr_q);

    assign rx_pop  = acc_start & rd_win & (rd_off == OFF_RXDATA) & ~rx_empty;
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_push = mem_write & wr_win & (wr_off == OFF_TXDATA);
    assign ram_we  = mem_write & ~wr_win;
    assign st_clr  = (mem_write & wr_win & (wr_off == OFF_STATUS)) ? mem_data_in : 8'h00;

    assign status = status_byte(~rx_empty, tx_full, tx_ovf_q, rx_ovf_q);

    byte_fifo #(.depth(fifo_depth)) u_rx_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (rx_valid),
        .push_data_i (rx_data),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .empty_o     (rx_empty),
        .full_o      (rx_full)
    );

    byte_fifo #(.depth(fifo_depth)) u_tx_fifo (
        .clk         (clk),
        .rst         (reset),
        .push_i      (tx_push),
        .push_data_i (mem_data_in),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .full_o      (tx_full)
    );

    assign tx_valid     = ~tx_empty;
    assign tx_data      = tx_empty ? 8'h00 : tx_head;
    assign mem_data_out = data_q;
    assign mem_ready    = ready_q;

    // Sticky flags: a new overflow event wins over a same-cycle clear.
    always_comb begin
        tx_ovf_d = (tx_ovf_q & ~st_clr[ST_TX_OVF]) | (tx_push & tx_full & ~tx_pop);
        rx_ovf_d = (rx_ovf_q & ~st_clr[ST_RX_OVF]) | (rx_valid & rx_full & ~rx_pop);
    end

    always_comb begin
        snap_d = snap_q;
        if (acc_start && rd_win && rd_off == OFF_CYCLES) snap_d = cnt_q;
        data_d = 8'h00;
        if (!rd_win) begin
            data_d = ram_q[mem_raddr];
        end else begin
            case (rd_off)
                // Holding RXDATA keeps the popped byte rather than peeking again.
                OFF_RXDATA:        data_d = acc_start ? (rx_empty ? 8'h00 : rx_head) : data_q;
                OFF_STATUS:        data_d = status;
                OFF_CYCLES:        data_d = snap_d[31:24];
                OFF_CYCLES + 4'd1: data_d = snap_q[23:16];
                OFF_CYCLES + 4'd2: data_d = snap_q[15:8];
                OFF_CYCLES + 4'd3: data_d = snap_q[7:0];
                default:           data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_raddr_q <= '0;
            first_q      <= 1'b1;
            ready_q      <= 1'b0;
            data_q       <= 8'h00;
            cnt_q        <= 32'd0;
            snap_q       <= 32'd0;
            tx_ovf_q     <= 1'b0;
            rx_ovf_q     <= 1'b0;
        end else begin
            prev_raddr_q <= mem_raddr;
            first_q      <= 1'b0;
            ready_q      <= 1'b1;
            data_q       <= data_d;
            cnt_q        <= cnt_q + 32'd1;
            snap_q       <= snap_d;
            tx_ovf_q     <= tx_ovf_d;
            rx_ovf_q     <= rx_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[mem_waddr] <= mem_data_in;
    end

endmodule

// File: tb/tb_memory_target.sv
// Self-checking bench for memory_target: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model of the responder.
module tb_memory_target;
    localparam int AW    = 9;
    localparam int DEPTH = 8;
    localparam int W     = 2**AW - 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [7:0]    mem_data_in, rx_data;
    logic          mem_write, tx_ready, rx_valid;
    logic [7:0]    mem_data_out, tx_data;
    logic          mem_ready, tx_valid;

    memory_target #(.addr_width(AW), .fifo_depth(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_raddr    (mem_raddr),
        .mem_data_out (mem_data_out),
        .mem_waddr    (mem_waddr),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [7:0]    m_ram [0:2**AW-1];
    bit            m_known [0:2**AW-1];
    logic [7:0]    m_rxq[$];
    logic [7:0]    m_txq[$];
    bit            m_rx_ovf, m_tx_ovf, m_first, m_ready, m_dknown;
    logic [31:0]   m_cyc, m_snap;
    logic [AW-1:0] m_prev;
    logic [7:0]    m_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rxq.delete();
        m_txq.delete();
        m_rx_ovf = 0; m_tx_ovf = 0;
        m_first  = 1; m_ready  = 0;
        m_cyc    = 0; m_snap   = 0;
        m_prev   = '0;
        m_dout   = 8'h00; m_dknown = 1;
    endtask

    task automatic idle_inputs();
        mem_write = 0; mem_waddr = '0; mem_data_in = 8'h00;
        rx_valid = 0; rx_data = 8'h00; tx_ready = 0;
    endtask

    // One clock: predict from current inputs, advance, compare outputs.
    task automatic step();
        logic [7:0]  nd, st;
        logic [31:0] ns;
        bit          nk, acc, rx_pop, tx_hs, tx_full, rx_full, set_tx, set_rx;
        logic [7:0]  clr;
        acc = m_first || (mem_raddr != m_prev);
        st  = {4'b0, m_rx_ovf, m_tx_ovf, (m_txq.size() == DEPTH), (m_rxq.size() != 0)};
        nd = 8'h00; nk = 1; rx_pop = 0; ns = m_snap;
        if (mem_raddr < W) begin
            nd = m_ram[mem_raddr]; nk = m_known[mem_raddr];
        end else begin
            if (acc && mem_raddr == AW'(W + 4)) ns = m_cyc;
            case (int'(mem_raddr) - W)
                0: if (acc) begin
                       if (m_rxq.size() != 0) begin nd = m_rxq[0]; rx_pop = 1; end
                   end else begin
                       nd = m_dout; nk = m_dknown;
                   end
                2: nd = st;
                4: nd = ns[31:24];
                5: nd = m_snap[23:16];
                6: nd = m_snap[15:8];
                7: nd = m_snap[7:0];
                default: nd = 8'h00;
            endcase
        end
        tx_hs   = (m_txq.size() != 0) && tx_ready;
        tx_full = (m_txq.size() == DEPTH);
        rx_full = (m_rxq.size() == DEPTH);
        set_tx = 0; set_rx = 0; clr = 8'h00;
        if (tx_hs) void'(m_txq.pop_front());
        if (mem_write) begin
            if (mem_waddr < W) begin
                m_ram[mem_waddr] = mem_data_in; m_known[mem_waddr] = 1;
            end else if (mem_waddr == AW'(W + 1)) begin
                if (!tx_full || tx_hs) m_txq.push_back(mem_data_in);
                else set_tx = 1;
            end else if (mem_waddr == AW'(W + 2)) begin
                clr = mem_data_in;
            end
        end
        if (rx_pop) void'(m_rxq.pop_front());
        if (rx_valid) begin
            if (!rx_full || rx_pop) m_rxq.push_back(rx_data);
            else set_rx = 1;
        end
        m_tx_ovf = (m_tx_ovf && !clr[2]) || set_tx;
        m_rx_ovf = (m_rx_ovf && !clr[3]) || set_rx;
        m_snap = ns; m_prev = mem_raddr; m_first = 0; m_ready = 1;
        m_cyc  = m_cyc + 1;
        m_dout = nd; m_dknown = nk;
        @(posedge clk);
        #1;
        chk("mem_ready", 32'(mem_ready), 32'(m_ready));
        if (m_dknown) chk("mem_data_out", 32'(mem_data_out), 32'(m_dout));
        chk("tx_valid", 32'(tx_valid), 32'(m_txq.size() != 0));
        chk("tx_data", 32'(tx_data), (m_txq.size() != 0) ? 32'(m_txq[0]) : 32'h0);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        mem_write = 1; mem_waddr = a; mem_data_in = d;
        step();
        mem_write = 0;
    endtask

    logic [31:0] cyc_val;
    int          hold;
    int          r;

    initial begin
        for (int i = 0; i < 2**AW; i++) m_known[i] = 0;
        idle_inputs();
        mem_raddr = '0;
        reset = 1;
        model_reset();
        #2;
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_dout", 32'(mem_data_out), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        @(posedge clk); #1;
        reset = 0;
        step();
        chk("ready_rise", 32'(mem_ready), 32'h1);

        // RAM round trip
        cpu_write(AW'(9'h010), 8'hA5);
        mem_raddr = AW'(9'h010);
        step();
        chk("ram_rt", 32'(mem_data_out), 32'hA5);
        step();
        chk("ram_hold", 32'(mem_data_out), 32'hA5);

        // TX path
        cpu_write(AW'(W + 1), 8'h41);
        cpu_write(AW'(W + 1), 8'h42);
        chk("tx_first_valid", 32'(tx_valid), 32'h1);
        chk("tx_first_data", 32'(tx_data), 32'h41);
        tx_ready = 1;
        step();
        chk("tx_second_data", 32'(tx_data), 32'h42);
        step();
        chk("tx_drained", 32'(tx_valid), 32'h0);
        tx_ready = 0;

        // TX overflow and sticky clear
        for (int i = 0; i < 9; i++) cpu_write(AW'(W + 1), 8'(i + 1));
        mem_raddr = AW'(W + 2);
        step();
        chk("tx_ovf_status", 32'(mem_data_out), 32'h06);
        cpu_write(AW'(W + 2), 8'h04);
        step();
        chk("tx_ovf_clear", 32'(mem_data_out), 32'h02);
        tx_ready = 1;
        for (int i = 0; i < 9; i++) step();
        tx_ready = 0;

        // RX path
        rx_valid = 1; rx_data = 8'h10; step();
        rx_data = 8'h20; step();
        rx_valid = 0;
        mem_raddr = AW'(W + 0);
        step();
        chk("rx_first", 32'(mem_data_out), 32'h10);
        step(); step();
        chk("rx_hold", 32'(mem_data_out), 32'h10);
        mem_raddr = AW'(W + 2);
        step();
        chk("rx_one_pop", 32'(mem_data_out), 32'h01);
        mem_raddr = AW'(W + 0);
        step();
        chk("rx_second", 32'(mem_data_out), 32'h20);
        mem_raddr = AW'(W + 3);
        step();
        mem_raddr = AW'(W + 0);
        step();
        chk("rx_empty_read", 32'(mem_data_out), 32'h00);
        mem_raddr = AW'(W + 2);
        step();
        chk("rx_empty_status", 32'(mem_data_out & 8'h01), 32'h0);

        // Reset mid-stream with TX bytes queued
        cpu_write(AW'(W + 1), 8'h61);
        cpu_write(AW'(W + 1), 8'h62);
        cpu_write(AW'(W + 1), 8'h63);
        chk("pre_reset_valid", 32'(tx_valid), 32'h1);
        mem_raddr = '0;
        reset = 1;
        model_reset();
        #1;
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_ready", 32'(mem_ready), 32'h0);
        @(posedge clk); #1;
        reset = 0;
        chk("ready_low_after_release", 32'(mem_ready), 32'h0);
        step();
        chk("ready_after_reset", 32'(mem_ready), 32'h1);
        mem_raddr = AW'(W + 2);
        step();
        chk("status_after_reset", 32'(mem_data_out), 32'h00);

        // CYCLES coherence across a low-byte carry
        mem_raddr = '0;
        for (int i = 0; i < 400 && m_cyc != 32'hFE; i++) step();
        chk("cycles_align", m_cyc, 32'hFE);
        mem_raddr = AW'(W + 4); step();
        cyc_val[31:24] = mem_data_out; step();
        mem_raddr = AW'(W + 5); step();
        cyc_val[23:16] = mem_data_out; step();
        mem_raddr = AW'(W + 6); step();
        cyc_val[15:8] = mem_data_out; step();
        mem_raddr = AW'(W + 7); step();
        cyc_val[7:0] = mem_data_out;
        chk("cycles_coherent", cyc_val, 32'h000000FE);

        // Random traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4)       mem_raddr = AW'(W + $urandom_range(0, 7));
                else if (r == 4) mem_raddr = AW'(W + $urandom_range(0, 15));
                else             mem_raddr = AW'($urandom_range(0, 15));
                hold = $urandom_range(1, 3);
            end
            hold--;
            mem_write = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            if (r < 8)       mem_waddr = AW'(W + 1);
            else if (r < 11) mem_waddr = AW'(W + 2);
            else if (r < 18) mem_waddr = AW'($urandom_range(0, 15));
            else             mem_waddr = AW'(W + $urandom_range(0, 15));
            mem_data_in = 8'($urandom);
            rx_valid    = ($urandom_range(0, 2) == 0);
            rx_data     = 8'($urandom);
            tx_ready    = ($urandom_range(0, 2) == 0);
            step();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
